// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants for the decode / register-file slice.
// Holds datapath widths, the architectural register numbers for $zero
// and $ra, and the write-select encoding used by the write-address mux
// (Rt / Rd / ra). wsel_addr() is that mux, so decode and the bench
// agree on which destination an instruction names.
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 2;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    WSEL_RT = 2'b00,
    WSEL_RD = 2'b01,
    WSEL_RA = 2'b10
  } wsel_e;

  // Write-address mux: pick the destination register for a write select.
  function automatic logic [ADDR_W-1:0] wsel_addr(input wsel_e sel,
                                                  input logic [ADDR_W-1:0] rt,
                                                  input logic [ADDR_W-1:0] rd);
    case (sel)
      WSEL_RT: return rt;
      WSEL_RD: return rd;
      WSEL_RA: return REG_RA;
      default: return REG_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode / write-back bus of the scoreboarded register file.
// master: decode + write-back side (drives issue, read addresses, wb).
// slave : register file (drives read data, stall, busy_vec, sb_err).
interface regfile_sb_if;

  logic                          issue_valid;
  logic [cpu_pkg::ADDR_W-1:0]    issue_waddr;
  logic                          rs_used;
  logic                          rt_used;
  logic [cpu_pkg::ADDR_W-1:0]    rs_addr;
  logic [cpu_pkg::ADDR_W-1:0]    rt_addr;
  logic [cpu_pkg::DATA_W-1:0]    rs_data;
  logic [cpu_pkg::DATA_W-1:0]    rt_data;
  logic                          wb_valid;
  logic [cpu_pkg::ADDR_W-1:0]    wb_addr;
  logic [cpu_pkg::DATA_W-1:0]    wb_data;
  logic                          stall;
  logic [cpu_pkg::NUM_REGS-1:0]  busy_vec;
  logic                          sb_err;

  modport master (
    output issue_valid, issue_waddr, rs_used, rt_used, rs_addr, rt_addr,
           wb_valid, wb_addr, wb_data,
    input  rs_data, rt_data, stall, busy_vec, sb_err
  );

  modport slave (
    input  issue_valid, issue_waddr, rs_used, rt_used, rs_addr, rt_addr,
           wb_valid, wb_addr, wb_data,
    output rs_data, rt_data, stall, busy_vec, sb_err
  );

endinterface

// File: rtl/sb_counter.sv
// sb_counter: pending-write counter for one architectural register.
// Ports: clk, rst_n (async active-low); i_inc (issue accepted),
// i_dec (write-back); o_count (pending writes), o_sat (count at max),
// o_busy (count non-zero), o_err (one-cycle pulse on underflow or on
// an increment past max -- the count holds in both cases).
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat,
  output logic             o_busy,
  output logic             o_err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_next;
  logic             w_err;

  // Next-count and error decode; inc and dec together cancel out.
  always_comb begin
    w_next = r_count;
    w_err  = 1'b0;
    case ({i_inc, i_dec})
      2'b10: begin
        if (r_count == CNT_MAX) begin
          w_err = 1'b1;
        end else begin
          w_next = r_count + CNT_W'(1);
        end
      end
      2'b01: begin
        if (r_count == CNT_ZERO) begin
          w_err = 1'b1;
        end else begin
          w_next = r_count - CNT_W'(1);
        end
      end
      default: w_next = r_count;
    endcase
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= CNT_ZERO;
    end else begin
      r_count <= w_next;
    end
  end

  assign o_count = r_count;
  assign o_sat   = (r_count == CNT_MAX);
  assign o_busy  = (r_count != CNT_ZERO);
  assign o_err   = w_err;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 32 x 32-bit register file with a write scoreboard.
// Ports: clk, rst_n (async active-low), bus (regfile_sb_if.slave):
//   issue_valid/issue_waddr  destination issued from decode
//   rs_/rt_used, rs_/rt_addr read requests, rs_/rt_data combinational data
//   wb_valid/wb_addr/wb_data write-back port (bypassed to the reads)
//   stall    RAW hazard or destination counter full
//   busy_vec registered per-register "pending write" flags
//   sb_err   sticky scoreboard error (underflow / overflow)
module regfile_sb
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave bus
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [CNT_W-1:0]    w_cnt  [NUM_REGS];
  logic [NUM_REGS-1:0] w_sat;
  logic [NUM_REGS-1:1] w_busy;
  logic [NUM_REGS-1:1] w_err;
  logic [NUM_REGS-1:1] w_inc;
  logic [NUM_REGS-1:1] w_dec;
  logic                w_rs_hit;
  logic                w_rt_hit;
  logic                w_iss_hit;
  logic                w_stall;
  logic                w_accept;
  logic [DATA_W-1:0]   w_rs_data;
  logic [DATA_W-1:0]   w_rt_data;
  logic                r_sb_err;

  // Register still busy after accounting for a write-back landing this cycle.
  function automatic logic busy_eff(input logic [CNT_W-1:0] cnt, input logic hit);
    return cnt > {{(CNT_W-1){1'b0}}, hit};
  endfunction

  // $zero has no counter: never busy, never saturated.
  assign w_cnt[0] = '0;
  assign w_sat[0] = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_inc[g]),
      .i_dec   (w_dec[g]),
      .o_count (w_cnt[g]),
      .o_sat   (w_sat[g]),
      .o_busy  (w_busy[g]),
      .o_err   (w_err[g])
    );
  end

  assign w_rs_hit  = bus.wb_valid && (bus.wb_addr == bus.rs_addr);
  assign w_rt_hit  = bus.wb_valid && (bus.wb_addr == bus.rt_addr);
  assign w_iss_hit = bus.wb_valid && (bus.wb_addr == bus.issue_waddr);

  // A full counter only blocks issue when no write-back frees a slot now.
  assign w_stall = (bus.rs_used && busy_eff(w_cnt[bus.rs_addr], w_rs_hit)) ||
                   (bus.rt_used && busy_eff(w_cnt[bus.rt_addr], w_rt_hit)) ||
                   (bus.issue_valid && w_sat[bus.issue_waddr] && !w_iss_hit);

  assign w_accept = bus.issue_valid && !w_stall && (bus.issue_waddr != REG_ZERO);

  // Per-register increment / decrement strobes.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_inc[r] = w_accept && (bus.issue_waddr == ADDR_W'(r));
      w_dec[r] = bus.wb_valid && (bus.wb_addr == ADDR_W'(r));
    end
  end

  // Register array; entry 0 is held at zero by never being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
    end else if (bus.wb_valid && (bus.wb_addr != REG_ZERO)) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // rs read port with write-through bypass.
  always_comb begin
    if (bus.rs_addr == REG_ZERO) begin
      w_rs_data = '0;
    end else if (w_rs_hit) begin
      w_rs_data = bus.wb_data;
    end else begin
      w_rs_data = r_regs[bus.rs_addr];
    end
  end

  // rt read port with write-through bypass.
  always_comb begin
    if (bus.rt_addr == REG_ZERO) begin
      w_rt_data = '0;
    end else if (w_rt_hit) begin
      w_rt_data = bus.wb_data;
    end else begin
      w_rt_data = r_regs[bus.rt_addr];
    end
  end

  // Sticky scoreboard error; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_err <= 1'b0;
    end else begin
      r_sb_err <= r_sb_err | (|w_err);
    end
  end

  assign bus.rs_data  = w_rs_data;
  assign bus.rt_data  = w_rt_data;
  assign bus.stall    = w_stall;
  assign bus.busy_vec = {w_busy, 1'b0};
  assign bus.sb_err   = r_sb_err;

endmodule
